// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CD-bus memory responder.
package cpu_mem_pkg;

    localparam int CD_W  = 16;
    localparam int PPN_W = 14;
    localparam int CA_W  = 10;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Even parity bit: makes the total count of ones in {parity, data} even.
    function automatic logic even_parity(input logic [CD_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Synchronous single-port word store with write enable and registered read.
// It has no reset, so unwritten words are undefined.
module mem_resp_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/mem_cd_responder.sv
// CD-bus memory responder: acknowledges CPU requests after WAIT_CYC wait states.
// Optional feature: define MEM_RESP_PARITY_EN to add a stored parity bit with error injection.
module mem_cd_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        sysclk,
    input  logic        sys_rst,
    input  logic        MREQ_n,
    input  logic        WRITE,
    input  logic [13:0] PPN_23_10,
    input  logic [9:0]  CA_9_0,
    input  logic [15:0] CD_15_0_IN,
    input  logic        ERRINJ,
    output logic [15:0] CD_15_0_OUT,
    output logic        DVACC_n,
    output logic        PARERR_n,
    output logic        BUSY
);

    localparam int AW = PPN_W + CA_W;
`ifdef MEM_RESP_PARITY_EN
    localparam int MEM_W = CD_W + 1;
`else
    localparam int MEM_W = CD_W;
`endif

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [AW-1:0]      addr_r;
    logic               wr_r;
    logic [CD_W-1:0]    data_r;
    logic               rd_valid_r;
    logic               dvacc_n_r;
    logic               busy_r;

    logic [AW-1:0]      req_addr_s;
    logic [AW-1:0]      cur_addr_s;
    logic               cur_wr_s;
    logic [CD_W-1:0]    cur_data_s;
    logic               enter_ack_s;
    logic               in_range_s;
    logic               ram_we_s;
    logic [MEM_W-1:0]   ram_wdata_s;
    logic [MEM_W-1:0]   ram_rdata_s;

    // In IDLE the request is taken straight from the bus so a zero-wait access can commit on its sampling edge.
    always_comb begin
        req_addr_s = {PPN_23_10, CA_9_0};
        if (state_r == IDLE) begin
            cur_addr_s = req_addr_s;
            cur_wr_s   = WRITE;
            cur_data_s = CD_15_0_IN;
        end else begin
            cur_addr_s = addr_r;
            cur_wr_s   = wr_r;
            cur_data_s = data_r;
        end
        case (state_r)
            IDLE:    enter_ack_s = !MREQ_n && (WAIT_CYC == 0);
            WAIT:    enter_ack_s = !MREQ_n && (cnt_r == CNT_W'(0));
            default: enter_ack_s = 1'b0;
        endcase
        in_range_s = ((cur_addr_s >> ADDR_W) == {AW{1'b0}});
        ram_we_s   = enter_ack_s && cur_wr_s && in_range_s;
    end

`ifdef MEM_RESP_PARITY_EN
    logic errinj_r;
    logic cur_errinj_s;

    // Error injection is latched with the request like the rest of the write.
    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            errinj_r <= 1'b0;
        end else if (state_r == IDLE && !MREQ_n) begin
            errinj_r <= ERRINJ;
        end
    end

    // Stored word carries even parity, optionally inverted to provoke a read error.
    always_comb begin
        if (state_r == IDLE) begin
            cur_errinj_s = ERRINJ;
        end else begin
            cur_errinj_s = errinj_r;
        end
        ram_wdata_s = {even_parity(cur_data_s) ^ cur_errinj_s, cur_data_s};
    end

    assign PARERR_n = !(rd_valid_r &&
                        (ram_rdata_s[CD_W] != even_parity(ram_rdata_s[CD_W-1:0])));
`else
    logic unused_errinj_s;
    assign unused_errinj_s = ERRINJ;
    assign ram_wdata_s     = cur_data_s;
    assign PARERR_n        = 1'b1;
`endif

    mem_resp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (MEM_W)
    ) u_ram (
        .clk   (sysclk),
        .we    (ram_we_s),
        .addr  (cur_addr_s[ADDR_W-1:0]),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Request FSM; the acknowledge and read-valid flags are registered on the edge that enters ACK.
    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_W'(0);
            addr_r     <= {AW{1'b0}};
            wr_r       <= 1'b0;
            data_r     <= {CD_W{1'b0}};
            rd_valid_r <= 1'b0;
            dvacc_n_r  <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            dvacc_n_r  <= !enter_ack_s;
            rd_valid_r <= enter_ack_s && !cur_wr_s && in_range_s;
            case (state_r)
                IDLE: begin
                    if (!MREQ_n) begin
                        addr_r <= req_addr_s;
                        wr_r   <= WRITE;
                        data_r <= CD_15_0_IN;
                        busy_r <= 1'b1;
                        if (WAIT_CYC == 0) begin
                            state_r <= ACK;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_W'(WAIT_CYC - 1);
                        end
                    end
                end
                WAIT: begin
                    if (MREQ_n) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_W'(0)) begin
                        state_r <= ACK;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ACK: begin
                    state_r <= HOLD;
                end
                HOLD: begin
                    if (MREQ_n) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read data is driven only for the single ACK cycle of an in-range read, so the bus ORs cleanly.
    assign CD_15_0_OUT = rd_valid_r ? ram_rdata_s[CD_W-1:0] : 16'h0000;
    assign DVACC_n     = dvacc_n_r;
    assign BUSY        = busy_r;

endmodule

// File: tb/tb_mem_cd_responder.sv
// Bench for mem_cd_responder: two instances (WAIT_CYC=2 and WAIT_CYC=0) checked every cycle
// against a timeline-based reference model, plus directed literal checks.
module tb_mem_cd_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        mreq_n [2];
    logic        wr     [2];
    logic [13:0] ppn    [2];
    logic [9:0]  ca     [2];
    logic [15:0] cdi    [2];
    logic        ei     [2];
    logic [15:0] cdo    [2];
    logic        dv_n   [2];
    logic        pe_n   [2];
    logic        busy   [2];

    mem_cd_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut0 (
        .sysclk(clk), .sys_rst(rst), .MREQ_n(mreq_n[0]), .WRITE(wr[0]),
        .PPN_23_10(ppn[0]), .CA_9_0(ca[0]), .CD_15_0_IN(cdi[0]), .ERRINJ(ei[0]),
        .CD_15_0_OUT(cdo[0]), .DVACC_n(dv_n[0]), .PARERR_n(pe_n[0]), .BUSY(busy[0]));

    mem_cd_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut1 (
        .sysclk(clk), .sys_rst(rst), .MREQ_n(mreq_n[1]), .WRITE(wr[1]),
        .PPN_23_10(ppn[1]), .CA_9_0(ca[1]), .CD_15_0_IN(cdi[1]), .ERRINJ(ei[1]),
        .CD_15_0_OUT(cdo[1]), .DVACC_n(dv_n[1]), .PARERR_n(pe_n[1]), .BUSY(busy[1]));

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    logic [23:0] pool [8] = '{24'h000005, 24'h000000, 24'h0003FF, 24'h000123,
                              24'h0002AA, 24'h000077, 24'h000400, 24'hFFFFFF};

`ifdef MEM_RESP_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic int slot_of(input logic [23:0] a);
        for (int s = 0; s < 8; s++) if (pool[s] == a) return s;
        return 0;
    endfunction

    // Reference model: per-instance request timeline and word store.
    bit          busy_m  [2] = '{1'b0, 1'b0};
    bit          acked_m [2] = '{1'b0, 1'b0};
    int          req_e   [2];
    int          ack_e   [2];
    logic        t_wr    [2];
    logic [23:0] t_addr  [2];
    logic [15:0] t_d     [2];
    logic        t_ei    [2];
    logic [15:0] mem_m   [2][8];
    bit          err_m   [2][8];
    logic        exp_dv  [2] = '{1'b1, 1'b1};
    logic        exp_pe  [2] = '{1'b1, 1'b1};
    logic        exp_busy[2] = '{1'b0, 1'b0};
    logic [15:0] exp_cd  [2] = '{16'h0, 16'h0};
    int          ecnt = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                busy_m[i] = 1'b0; acked_m[i] = 1'b0;
                exp_dv[i] = 1'b1; exp_pe[i] = 1'b1; exp_busy[i] = 1'b0; exp_cd[i] = 16'h0;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                exp_dv[i] = 1'b1; exp_cd[i] = 16'h0; exp_pe[i] = 1'b1;
                if (!busy_m[i]) begin
                    if (mreq_n[i] == 1'b0) begin
                        busy_m[i] = 1'b1; acked_m[i] = 1'b0; req_e[i] = ecnt;
                        t_wr[i] = wr[i]; t_addr[i] = {ppn[i], ca[i]};
                        t_d[i] = cdi[i]; t_ei[i] = ei[i];
                    end
                end else if (!acked_m[i]) begin
                    if (mreq_n[i]) busy_m[i] = 1'b0;
                end else if (ecnt >= ack_e[i] + 2 && mreq_n[i]) begin
                    busy_m[i] = 1'b0;
                end
                if (busy_m[i] && !acked_m[i] && ecnt == req_e[i] + (i == 0 ? 2 : 0)) begin
                    acked_m[i] = 1'b1; ack_e[i] = ecnt; exp_dv[i] = 1'b0;
                    if (t_addr[i] < 24'd1024) begin
                        if (t_wr[i]) begin
                            mem_m[i][slot_of(t_addr[i])] = t_d[i];
                            err_m[i][slot_of(t_addr[i])] = t_ei[i];
                        end else begin
                            exp_cd[i] = mem_m[i][slot_of(t_addr[i])];
                            exp_pe[i] = !(PAR_EN && err_m[i][slot_of(t_addr[i])]);
                        end
                    end
                end
                exp_busy[i] = busy_m[i];
            end
        end
    end

    // Cycle-by-cycle comparison, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("dvacc_n%0d", i), {31'd0, dv_n[i]}, {31'd0, exp_dv[i]});
                check($sformatf("cd_out%0d", i),  {16'd0, cdo[i]},  {16'd0, exp_cd[i]});
                check($sformatf("busy%0d", i),    {31'd0, busy[i]}, {31'd0, exp_busy[i]});
                check($sformatf("parerr_n%0d", i), {31'd0, pe_n[i]}, {31'd0, exp_pe[i]});
            end
        end
    end

    task automatic do_req(input int i, input logic w, input logic [23:0] a, input logic [15:0] d,
                          input logic e, input int hold,
                          output int lat, output logic [15:0] rd, output logic pe);
        @(negedge clk);
        mreq_n[i] = 1'b0; wr[i] = w; {ppn[i], ca[i]} = a; cdi[i] = d; ei[i] = e;
        lat = -1; rd = 16'h0; pe = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                wr[i] = 1'($urandom); {ppn[i], ca[i]} = 24'($urandom);
                cdi[i] = 16'($urandom); ei[i] = 1'($urandom);
            end
            if (dv_n[i] == 1'b0) begin
                lat = c; rd = cdo[i]; pe = pe_n[i];
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            $display("FAIL ack_timeout inst %0d: no DVACC_n within 20 cycles, required one", i);
        end
        repeat (hold) @(negedge clk);
        mreq_n[i] = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_abort(input logic [23:0] a, input logic [15:0] d, input int k);
        @(negedge clk);
        mreq_n[0] = 1'b0; wr[0] = 1'b1; {ppn[0], ca[0]} = a; cdi[0] = d; ei[0] = 1'b0;
        repeat (k) @(negedge clk);
        mreq_n[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_busy", {31'd0, busy[0]}, 32'd0);
    endtask

    int          lat;
    logic [15:0] rd;
    logic        pe;

    initial begin
        for (int i = 0; i < 2; i++) begin
            mreq_n[i] = 1'b1; wr[i] = 1'b0; ppn[i] = 14'h0; ca[i] = 10'h0;
            cdi[i] = 16'h0; ei[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;
        check("rst_dvacc_n", {31'd0, dv_n[0]}, 32'd1);
        check("rst_busy",    {31'd0, busy[0]}, 32'd0);
        check("rst_cd_out",  {16'd0, cdo[0]},  32'd0);
        check("rst_parerr_n", {31'd0, pe_n[0]}, 32'd1);

        // Two wait states: write then read back.
        do_req(0, 1'b1, 24'h000005, 16'hA5C3, 1'b0, 0, lat, rd, pe);
        check("w2_latency", lat, 32'd2);
        do_req(0, 1'b0, 24'h000005, 16'h0000, 1'b0, 0, lat, rd, pe);
        check("r2_latency", lat, 32'd2);
        check("r2_data", {16'd0, rd}, 32'h0000A5C3);

        // Zero wait states, request held long after the acknowledge.
        do_req(1, 1'b1, 24'h0003FF, 16'h1234, 1'b0, 0, lat, rd, pe);
        check("w0_latency", lat, 32'd0);
        do_req(1, 1'b0, 24'h0003FF, 16'h0000, 1'b0, 5, lat, rd, pe);
        check("r0_latency", lat, 32'd0);
        check("r0_data", {16'd0, rd}, 32'h00001234);

        // Aborts early in WAIT and on the last WAIT cycle leave the word intact.
        do_abort(24'h000005, 16'hDEAD, 1);
        do_abort(24'h000005, 16'hBEEF, 2);
        do_req(0, 1'b0, 24'h000005, 16'h0000, 1'b0, 0, lat, rd, pe);
        check("abort_keeps", {16'd0, rd}, 32'h0000A5C3);

        // Out-of-range write/read are acknowledged, dropped and read as zero.
        do_req(0, 1'b1, 24'h000000, 16'h5A5A, 1'b0, 0, lat, rd, pe);
        do_req(0, 1'b1, 24'h000400, 16'hFFFF, 1'b0, 0, lat, rd, pe);
        check("oor_w_ack", lat, 32'd2);
        do_req(0, 1'b0, 24'h000400, 16'h0000, 1'b0, 0, lat, rd, pe);
        check("oor_r_ack", lat, 32'd2);
        check("oor_r_data", {16'd0, rd}, 32'd0);
        check("oor_parerr_n", {31'd0, pe}, 32'd1);
        do_req(0, 1'b0, 24'h000000, 16'h0000, 1'b0, 0, lat, rd, pe);
        check("oor_no_alias", {16'd0, rd}, 32'h00005A5A);

        // Parity error injection and clean parity.
        do_req(0, 1'b1, 24'h000123, 16'h0001, 1'b1, 0, lat, rd, pe);
        do_req(0, 1'b0, 24'h000123, 16'h0000, 1'b0, 0, lat, rd, pe);
        check("par_inject", {31'd0, pe}, PAR_EN ? 32'd0 : 32'd1);
        check("par_inject_data", {16'd0, rd}, 32'h00000001);
        do_req(0, 1'b1, 24'h000123, 16'h0001, 1'b0, 0, lat, rd, pe);
        do_req(0, 1'b0, 24'h000123, 16'h0000, 1'b0, 0, lat, rd, pe);
        check("par_clean", {31'd0, pe}, 32'd1);

        // Reset during WAIT of a write.
        @(negedge clk);
        mreq_n[0] = 1'b0; wr[0] = 1'b1; {ppn[0], ca[0]} = 24'h000005; cdi[0] = 16'hBEEF;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_dvacc_n", {31'd0, dv_n[0]}, 32'd1);
        check("rst_mid_busy",    {31'd0, busy[0]}, 32'd0);
        @(negedge clk);
        mreq_n[0] = 1'b1;
        rst = 1'b0;
        do_req(0, 1'b0, 24'h000005, 16'h0000, 1'b0, 0, lat, rd, pe);
        check("rst_mid_keeps", {16'd0, rd}, 32'h0000A5C3);

        // Preload every in-range pool word in both instances, then random traffic.
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 6; s++)
                do_req(i, 1'b1, pool[s], 16'($urandom), 1'($urandom_range(0, 1)), 0, lat, rd, pe);
        repeat (80) begin
            automatic int i = $urandom_range(0, 1);
            automatic logic [23:0] a = pool[$urandom_range(0, 7)];
            if (i == 0 && $urandom_range(0, 5) == 0)
                do_abort(a, 16'($urandom), $urandom_range(1, 2));
            else
                do_req(i, 1'($urandom), a, 16'($urandom), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), lat, rd, pe);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
